mem_port_arbiter: RTL

//  Shares one single-port, synchronous-read word memory (the SOC's MEM array)

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port, synchronous-read word memory between the core's
// instruction-fetch port (i_*) and its load/store data port (d_*).
//
// Each requester uses a single-beat handshake: it raises its req, holds its
// address (and store data) stable, and waits for a one-cycle valid pulse.
// An access takes two cycles: a grant cycle in IDLE that strobes the memory,
// then a response cycle in which the memory's read data is returned.
//
// The data port normally wins a simultaneous request. A streak counter
// tracks how many data grants have been issued back to back while fetch
// was waiting. Once it reaches MAX_DSTREAK, fetch wins the next tie, so
// instruction fetch is never starved.
//
// Parameters
//   ADDR_W       word-address width (2^ADDR_W words)
//   MAX_DSTREAK  max consecutive data grants while i_req waits (>= 1)
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   i_req      fetch request, held until i_valid
//   i_addr     fetch word address
//   i_rdata    fetch read data, qualified by i_valid
//   i_valid    one-cycle fetch completion pulse
//   d_req      data request, held until d_valid
//   d_we       1 = store, 0 = load
//   d_wmask    byte-lane write enables for stores
//   d_addr     data word address
//   d_wdata    store data
//   d_rdata    load read data, qualified by d_valid
//   d_valid    one-cycle load/store completion pulse
//   mem_en     memory access strobe
//   mem_we     per-byte memory write enables
//   mem_addr   memory word address
//   mem_wdata  memory write data
//   mem_rdata  memory read data, valid the cycle after mem_en

module mem_port_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_valid,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wmask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_valid,

  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Counter must be able to hold the value MAX_DSTREAK itself.
  localparam int DW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [DW-1:0] MAX_CNT = DW'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] dstreak;

  logic          streak_full;
  logic          grant_d;
  logic          grant_i;

  // Arbitration happens combinationally in the IDLE cycle so the memory is
  // strobed in the same cycle the request is seen. Data wins ties unless it
  // has already used up its allowed streak while fetch was waiting.
  always_comb begin
    streak_full = (dstreak == MAX_CNT);
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    if (state == IDLE) begin
      if (d_req && !(i_req && streak_full)) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  // Memory-side drive. Strobes and write enables are forced low during
  // reset so an in-flight or newly presented request cannot touch memory.
  // Address and write data are don't-care when mem_en is low, so they are
  // left ungated to keep the path short.
  always_comb begin
    mem_en    = !reset && (grant_d || grant_i);
    mem_we    = (!reset && grant_d && d_we) ? d_wmask : 4'b0000;
    mem_addr  = grant_d ? d_addr : i_addr;
    mem_wdata = d_wdata;
  end

  // Requester-side response. Read data is passed straight through from the
  // memory; consumers only look at it while their valid is high. The valid
  // pulses follow the registered state, gated by reset so a response cycle
  // interrupted by reset never completes.
  always_comb begin
    i_rdata = mem_rdata;
    d_rdata = mem_rdata;
    i_valid = !reset && (state == RESP_I);
    d_valid = !reset && (state == RESP_D);
  end

  // Control FSM and streak counter. A grant always costs exactly one
  // response cycle, after which the arbiter returns to IDLE and samples the
  // requests again, so a requester holding req through its valid cycle is
  // never granted twice. The streak only grows when data wins while fetch
  // is actually waiting; any fetch grant, or a data grant with no fetch
  // pending, clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      dstreak <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state <= RESP_D;
            if (i_req) begin
              dstreak <= streak_full ? MAX_CNT : dstreak + DW'(1);
            end else begin
              dstreak <= '0;
            end
          end else if (grant_i) begin
            state   <= RESP_I;
            dstreak <= '0;
          end
        end
        RESP_I:  state <= IDLE;
        RESP_D:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
